// File: rtl/song_sequencer.sv
// ---------------------------------------------------------------------------
// song_sequencer
//
// Steps a square-wave tone generator through a melody held in an external
// synchronous note ROM. For each note the sequencer presents the ROM address
// (FETCH), captures the returned 24-bit tone period (LOAD), and then holds
// that period on the tone generator for a fixed number of clock cycles
// (PLAY). After the last address it wraps to address 0 and keeps looping.
// A single-cycle play_pause pulse starts, pauses and resumes playback. A
// single-cycle restart pulse returns playback to address 0.
//
// Parameters:
//   CYCLES_PER_NOTE  note duration in clk cycles (>= 1)
//   ADDR_WIDTH       note ROM address width
//   LAST_ADDR        last ROM address played before wrapping to 0
//
// Ports:
//   clk                 system clock, everything on the rising edge
//   rst_n               synchronous active-low reset
//   play_pause          single-cycle pulse: start / pause / resume
//   restart             single-cycle pulse: go back to address 0
//   rom_addr            note ROM read address
//   rom_data            note ROM data, valid one cycle after rom_addr
//                       (0 = rest)
//   tone_switch_period  period sent to the tone generator
//   output_enable       enable sent to the tone generator
//   playing             high in FETCH, LOAD and PLAY
//   state_dbg           current FSM state, for observation only
//
// Handshake: there is no valid/ready flow control here. Button inputs are
// one-cycle pulses that are acted on in the cycle they are sampled. The ROM
// is a fixed-latency read: an address held through FETCH returns its data
// during LOAD, and LOAD captures that data.
// ---------------------------------------------------------------------------
module song_sequencer #(
    parameter int CYCLES_PER_NOTE = 25_000_000,
    parameter int ADDR_WIDTH      = 9,
    parameter int LAST_ADDR       = 511
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  play_pause,
    input  logic                  restart,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [23:0]           rom_data,
    output logic [23:0]           tone_switch_period,
    output logic                  output_enable,
    output logic                  playing,
    output logic [2:0]            state_dbg
);

    // The counter only counts down from CYCLES_PER_NOTE-1, so clog2 bits
    // are enough. It is kept at least 1 bit wide for CYCLES_PER_NOTE = 1.
    localparam int CNT_W = (CYCLES_PER_NOTE > 1) ? $clog2(CYCLES_PER_NOTE) : 1;

    localparam logic [CNT_W-1:0]      CNT_LOAD  = CNT_W'(CYCLES_PER_NOTE - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]      CNT_ZERO  = '0;
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(LAST_ADDR);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LOAD   = 3'd2,
        S_PLAY   = 3'd3,
        S_PAUSED = 3'd4
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] note_cnt;
    // Records a play_pause that arrives while a note is being fetched or
    // loaded. The pause is then applied on the first PLAY cycle.
    logic             pause_pending;

    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state              <= S_IDLE;
            rom_addr           <= '0;
            tone_switch_period <= '0;
            output_enable      <= 1'b0;
            playing            <= 1'b0;
            note_cnt           <= CNT_ZERO;
            pause_pending      <= 1'b0;
        end else if (restart) begin
            // restart takes priority over play_pause. When a note sequence
            // is active, it starts again from address 0 at once. From IDLE
            // or PAUSED it goes back to the stopped state.
            rom_addr           <= '0;
            tone_switch_period <= '0;
            output_enable      <= 1'b0;
            pause_pending      <= 1'b0;
            if (state == S_FETCH || state == S_LOAD || state == S_PLAY) begin
                state   <= S_FETCH;
                playing <= 1'b1;
            end else begin
                state   <= S_IDLE;
                playing <= 1'b0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    output_enable <= 1'b0;
                    if (play_pause) begin
                        state   <= S_FETCH;
                        playing <= 1'b1;
                    end
                end

                // rom_addr is held through this cycle so the ROM can return
                // its data. The previous note keeps sounding.
                S_FETCH: begin
                    if (play_pause) begin
                        pause_pending <= 1'b1;
                    end
                    state <= S_LOAD;
                end

                S_LOAD: begin
                    if (play_pause) begin
                        pause_pending <= 1'b1;
                    end
                    tone_switch_period <= rom_data;
                    output_enable      <= (rom_data != 24'd0);
                    note_cnt           <= CNT_LOAD;
                    state              <= S_PLAY;
                end

                S_PLAY: begin
                    if (pause_pending || play_pause) begin
                        // The counter is frozen so that resuming finishes
                        // only the remaining part of the note.
                        state         <= S_PAUSED;
                        output_enable <= 1'b0;
                        playing       <= 1'b0;
                        pause_pending <= 1'b0;
                    end else if (note_cnt == CNT_ZERO) begin
                        rom_addr <= (rom_addr == ADDR_LAST) ? '0 : rom_addr + ADDR_ONE;
                        state    <= S_FETCH;
                    end else begin
                        note_cnt <= note_cnt - CNT_ONE;
                    end
                end

                S_PAUSED: begin
                    output_enable <= 1'b0;
                    if (play_pause) begin
                        state         <= S_PLAY;
                        playing       <= 1'b1;
                        output_enable <= (tone_switch_period != 24'd0);
                    end
                end

                default: begin
                    state         <= S_IDLE;
                    output_enable <= 1'b0;
                    playing       <= 1'b0;
                    pause_pending <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_song_sequencer.sv
module tb_song_sequencer;

  localparam int CPN  = 4;
  localparam int AW   = 2;
  localparam int LAST = 3;

  logic          clk;
  logic          rst_n;
  logic          play_pause;
  logic          restart;
  logic [AW-1:0] rom_addr;
  logic [23:0]   rom_data;
  logic [23:0]   tone_switch_period;
  logic          output_enable;
  logic          playing;
  logic [2:0]    state_dbg;

  logic [23:0] rom_mem [0:3];

  int total = 0;
  int bad   = 0;

  // ---------------- clock / reset / DUT ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  song_sequencer #(
    .CYCLES_PER_NOTE(CPN),
    .ADDR_WIDTH     (AW),
    .LAST_ADDR      (LAST)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .play_pause        (play_pause),
    .restart           (restart),
    .rom_addr          (rom_addr),
    .rom_data          (rom_data),
    .tone_switch_period(tone_switch_period),
    .output_enable     (output_enable),
    .playing           (playing),
    .state_dbg         (state_dbg)
  );

  // synchronous note ROM: one cycle of read latency
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  logic [27:0] dut_vec;
  assign dut_vec = {rom_addr, tone_switch_period, output_enable, playing};

  // ---------------- reference model ----------------
  // Tracks the player's phase and the number of PLAY cycles left in the
  // current note.
  localparam int M_IDLE = 0, M_FETCH = 1, M_LOAD = 2, M_PLAY = 3, M_PAUSED = 4;
  int          m_phase = M_IDLE;
  int          m_left  = 0;
  logic [1:0]  m_addr  = '0;
  logic [23:0] m_period = '0;
  logic        m_oe    = 1'b0;
  logic        m_pend  = 1'b0;

  function automatic logic [27:0] exp_vec();
    logic act;
    act = (m_phase == M_FETCH) || (m_phase == M_LOAD) || (m_phase == M_PLAY);
    return {m_addr, m_period, m_oe, act};
  endfunction

  task automatic model_step(input logic pp, input logic rs, input logic rn);
    if (!rn) begin
      m_phase = M_IDLE; m_addr = '0; m_period = '0; m_oe = 1'b0; m_pend = 1'b0; m_left = 0;
    end else if (rs) begin
      m_addr = '0; m_period = '0; m_oe = 1'b0; m_pend = 1'b0;
      m_phase = (m_phase == M_IDLE || m_phase == M_PAUSED) ? M_IDLE : M_FETCH;
    end else begin
      case (m_phase)
        M_IDLE:  if (pp) m_phase = M_FETCH;
        M_FETCH: begin
          if (pp) m_pend = 1'b1;
          m_phase = M_LOAD;
        end
        M_LOAD: begin
          if (pp) m_pend = 1'b1;
          m_period = rom_mem[m_addr];
          m_oe     = (m_period != 0);
          m_left   = CPN;
          m_phase  = M_PLAY;
        end
        M_PLAY: begin
          if (m_pend || pp) begin
            m_phase = M_PAUSED; m_oe = 1'b0; m_pend = 1'b0;
          end else if (m_left == 1) begin
            m_addr  = 2'((int'(m_addr) + 1) % (LAST + 1));
            m_phase = M_FETCH;
          end else begin
            m_left = m_left - 1;
          end
        end
        default: begin
          if (pp) begin
            m_phase = M_PLAY;
            m_oe    = (m_period != 0);
          end
        end
      endcase
    end
  endtask

  // ---------------- driver ----------------
  task automatic tick(input logic pp, input logic rs, input logic rn);
    play_pause = pp;
    restart    = rs;
    rst_n      = rn;
    @(posedge clk);
    model_step(pp, rs, rn);
    #1;
    play_pause = 1'b0;
    restart    = 1'b0;
    rst_n      = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    tick(0, 0, 0);
    tick(1, 1, 0);
    total++;
    if (dut_vec !== 28'd0) begin
      bad++;
      $display("FAIL reset_vals got=%h want=%h", dut_vec, 28'd0);
    end
    for (int i = 0; i < 10; i++) begin
      tick(0, 0, 1);
      total++;
      if (dut_vec !== 28'd0 || dut_vec !== exp_vec()) begin
        bad++;
        $display("FAIL idle_hold cycle=%0d got=%h want=%h", i, dut_vec, 28'd0);
      end
    end
  endtask

  task automatic test_sequence();
    logic [23:0] exp_q[$];
    logic [23:0] want_p;
    exp_q = {24'd100, 24'd0, 24'd300, 24'd400, 24'd100};
    tick(0, 0, 0);
    tick(1, 0, 1);
    for (int k = 1; k <= 30; k++) begin
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++;
        $display("FAIL seq_model k=%0d got=%h want=%h", k, dut_vec, exp_vec());
      end
      // each note occupies FETCH + LOAD + CPN PLAY cycles
      total++;
      if (rom_addr !== 2'(((k - 1) / (CPN + 2)) % (LAST + 1)) || playing !== 1'b1) begin
        bad++;
        $display("FAIL seq_addr k=%0d got addr=%0d playing=%b want addr=%0d playing=1",
                 k, rom_addr, playing, ((k - 1) / (CPN + 2)) % (LAST + 1));
      end
      if (k >= 3 && ((k - 3) % (CPN + 2)) == 0 && exp_q.size() > 0) begin
        want_p = exp_q.pop_front();
        total++;
        if (tone_switch_period !== want_p || output_enable !== (want_p != 0)) begin
          bad++;
          $display("FAIL seq_period k=%0d got per=%0d oe=%b want per=%0d",
                   k, tone_switch_period, output_enable, want_p);
        end
      end
      tick(0, 0, 1);
    end
  endtask

  task automatic test_pause_mid_note();
    int on_cnt;
    tick(0, 0, 0);
    tick(1, 0, 1);
    for (int k = 2; k <= 16; k++) tick(0, 0, 1);
    // state now in the 2nd PLAY cycle of note 300
    tick(1, 0, 1);
    for (int i = 0; i < 20; i++) begin
      total++;
      if (output_enable !== 1'b0 || tone_switch_period !== 24'd300 || rom_addr !== 2'd2 ||
          playing !== 1'b0 || dut_vec !== exp_vec()) begin
        bad++;
        $display("FAIL pause_hold i=%0d got=%h want=%h", i, dut_vec, exp_vec());
      end
      tick(0, 0, 1);
    end
    tick(1, 0, 1);
    on_cnt = 0;
    for (int i = 0; i < 10 && rom_addr == 2'd2; i++) begin
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++;
        $display("FAIL pause_resume i=%0d got=%h want=%h", i, dut_vec, exp_vec());
      end
      if (output_enable === 1'b1) on_cnt++;
      tick(0, 0, 1);
    end
    // the counter froze at 2 during the pausing cycle, so 2,1,0 remain
    total++;
    if (on_cnt != 3) begin
      bad++;
      $display("FAIL pause_remaining got=%0d want=3", on_cnt);
    end
  endtask

  task automatic test_pause_in_fetch();
    int on_cnt;
    tick(0, 0, 0);
    tick(1, 0, 1);
    tick(1, 0, 1);
    tick(0, 0, 1);
    total++;
    if (tone_switch_period !== 24'd100 || output_enable !== 1'b1 || dut_vec !== exp_vec()) begin
      bad++;
      $display("FAIL fetch_pause_play got=%h want=%h", dut_vec, exp_vec());
    end
    tick(0, 0, 1);
    total++;
    if (output_enable !== 1'b0 || playing !== 1'b0 || dut_vec !== exp_vec()) begin
      bad++;
      $display("FAIL fetch_pause_paused got=%h want=%h", dut_vec, exp_vec());
    end
    tick(0, 0, 1);
    tick(0, 0, 1);
    tick(1, 0, 1);
    on_cnt = 0;
    for (int i = 0; i < 10 && rom_addr == 2'd0; i++) begin
      if (output_enable === 1'b1) on_cnt++;
      tick(0, 0, 1);
    end
    total++;
    if (on_cnt != CPN) begin
      bad++;
      $display("FAIL fetch_pause_full got=%0d want=%0d", on_cnt, CPN);
    end
  endtask

  task automatic test_restart();
    tick(0, 0, 0);
    tick(1, 0, 1);
    for (int k = 2; k <= 16; k++) tick(0, 0, 1);
    tick(0, 1, 1);
    total++;
    if (rom_addr !== 2'd0 || tone_switch_period !== 24'd0 || output_enable !== 1'b0 ||
        playing !== 1'b1 || dut_vec !== exp_vec()) begin
      bad++;
      $display("FAIL restart_play got=%h want=%h", dut_vec, exp_vec());
    end
    tick(0, 0, 1);
    tick(0, 0, 1);
    total++;
    if (tone_switch_period !== 24'd100 || output_enable !== 1'b1 || dut_vec !== exp_vec()) begin
      bad++;
      $display("FAIL restart_first_note got=%h want=%h", dut_vec, exp_vec());
    end
    // advance to note 300 and pause it, then restart from PAUSED
    for (int i = 0; i < 30 && !(m_phase == M_PLAY && m_addr == 2'd2); i++) tick(0, 0, 1);
    tick(1, 0, 1);
    tick(0, 1, 1);
    total++;
    if (rom_addr !== 2'd0 || playing !== 1'b0 || tone_switch_period !== 24'd0 ||
        output_enable !== 1'b0 || dut_vec !== exp_vec()) begin
      bad++;
      $display("FAIL restart_paused got=%h want=%h", dut_vec, exp_vec());
    end
    // simultaneous restart and play_pause while playing
    tick(1, 0, 1);
    for (int i = 0; i < 30 && !(m_phase == M_PLAY && m_addr == 2'd2); i++) tick(0, 0, 1);
    tick(1, 1, 1);
    total++;
    if (rom_addr !== 2'd0 || playing !== 1'b1 || output_enable !== 1'b0 || dut_vec !== exp_vec()) begin
      bad++;
      $display("FAIL restart_beats_pp got=%h want=%h", dut_vec, exp_vec());
    end
    tick(0, 0, 1);
    tick(0, 0, 1);
    tick(0, 0, 1);
    total++;
    if (tone_switch_period !== 24'd100 || output_enable !== 1'b1 || playing !== 1'b1 ||
        dut_vec !== exp_vec()) begin
      bad++;
      $display("FAIL restart_pp_dropped got=%h want=%h", dut_vec, exp_vec());
    end
    // reset in the middle of PLAY
    tick(0, 0, 0);
    total++;
    if (dut_vec !== 28'd0) begin
      bad++;
      $display("FAIL reset_mid_play got=%h want=%h", dut_vec, 28'd0);
    end
  endtask

  task automatic test_random();
    logic pp, rs, rn;
    tick(0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      pp = ($urandom_range(0, 7) == 0);
      rs = ($urandom_range(0, 39) == 0);
      rn = ($urandom_range(0, 199) != 0);
      tick(pp, rs, rn);
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++;
        $display("FAIL random i=%0d pp=%b rs=%b rn=%b got=%h want=%h", i, pp, rs, rn, dut_vec, exp_vec());
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rom_mem[0] = 24'd100;
    rom_mem[1] = 24'd0;
    rom_mem[2] = 24'd300;
    rom_mem[3] = 24'd400;
    rst_n      = 1'b0;
    play_pause = 1'b0;
    restart    = 1'b0;
    test_reset();
    test_sequence();
    test_pause_mid_note();
    test_pause_in_fetch();
    test_restart();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
